div1: RTL and testbench



---
 rtl/div_pkg.sv | 14 +
 rtl/div1_step.sv | 26 ++
 rtl/div1.sv | 181 ++++++++++++++++++
 tb/tb_div1.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encodings and default width for the div1/mult1 arithmetic units
package div_pkg;

    // Default operand/result width for the sequential arithmetic units
    localparam int DIV_WIDTH_DEFAULT = 32;

    // Handshake state encodings, common to div1 and mult1 so one host FSM drives both
    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } div_state_t;

endpackage

// File: rtl/div1_step.sv
// rtl/div1_step.sv - one restoring-division iteration: shift {R,Q}, trial subtract, select
module div1_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    // Partial remainder after the shift keeps the bit pushed out of R, hence WIDTH+1 bits
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;
    logic           borrow;

    // Shift, subtract and restore; R < D holds on entry, so trial[WIDTH] is exactly the borrow
    always_comb begin
        rem_shift = {rem_in, quo_in[WIDTH-1]};
        trial     = rem_shift - {1'b0, divisor};
        borrow    = trial[WIDTH];
        quo_out   = {quo_in[WIDTH-2:0], ~borrow};
        rem_out   = borrow ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/div1.sv
// rtl/div1.sv - sequential restoring divider, one quotient bit per clock, start/ack handshake (DIV1_SIGNED_EN selects two's-complement operands)
module div1
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ack,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_t       state;
    div_state_t       state_next;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_d;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] step_r;
    logic             last_iter;
    logic             divisor_zero;

    // Operand magnitudes fed into the datapath and sign-corrected results leaving it
    logic [WIDTH-1:0] mag_dividend;
    logic [WIDTH-1:0] mag_divisor;
    logic [WIDTH-1:0] q_result;
    logic [WIDTH-1:0] r_result;

    assign last_iter    = (count == CW'(WIDTH - 1));
    assign divisor_zero = (divisor == '0);

    div1_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (acc_r),
        .quo_in  (acc_q),
        .divisor (acc_d),
        .rem_out (step_r),
        .quo_out (step_q)
    );

`ifdef DIV1_SIGNED_EN
    // Sign flags captured at start; the fix-up rides on the COMPUTE->DONE edge
    logic q_neg;
    logic r_neg;

    // Divide magnitudes; quotient negated on sign mismatch, remainder follows the dividend
    always_comb begin
        mag_dividend = dividend[WIDTH-1] ? -dividend : dividend;
        mag_divisor  = divisor[WIDTH-1]  ? -divisor  : divisor;
        q_result     = q_neg ? -step_q : step_q;
        r_result     = r_neg ? -step_r : step_r;
    end

    // Latch operand signs when a non-zero division is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == S_INIT && start && !divisor_zero) begin
            q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg <= dividend[WIDTH-1];
        end
    end
`else
    // Unsigned build: operands and results pass straight through
    always_comb begin
        mag_dividend = dividend;
        mag_divisor  = divisor;
        q_result     = step_q;
        r_result     = step_r;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start only counts in INIT, ack only in DONE (ack wins over start there)
    always_comb begin
        state_next = state;
        case (state)
            S_INIT: begin
                if (start) begin
                    state_next = divisor_zero ? S_DONE : S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (ack) begin
                    state_next = S_INIT;
                end
            end
            default: state_next = S_INIT;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_COMPUTE: busy = 1'b1;
            S_DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: latch operands, iterate one bit per edge, publish results on the last iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            acc_r       <= '0;
            acc_d       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (start) begin
                        if (divisor_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            acc_q       <= mag_dividend;
                            acc_d       <= mag_divisor;
                            acc_r       <= '0;
                            count       <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                S_COMPUTE: begin
                    acc_q <= step_q;
                    acc_r <= step_r;
                    count <= count + CW'(1);
                    if (last_iter) begin
                        quotient  <= q_result;
                        remainder <= r_result;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    div_by_zero <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div1.sv
// tb/tb_div1.sv - scoreboard bench for div1 against an arithmetic reference model
module tb_div1;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         ack = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    div1 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ack         (ack),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: plain integer division; zero divisor gives all-ones quotient and the dividend back
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        e.z = (b == 0);
        if (b == 0) begin
            e.q = '1;
            e.r = a;
        end else begin
`ifdef DIV1_SIGNED_EN
            sa = longint'($signed(a));
            sb = longint'($signed(b));
`else
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
`endif
            lq = sa / sb;
            lr = sa % sb;
            e.q = lq[W-1:0];
            e.r = lr[W-1:0];
        end
        return e;
    endfunction

    // Monitor: every rising done pops one expectation and compares the presented result
    always @(negedge clk) begin
        if (rst_n && done && !done_prev) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no pending operation");
            end else begin
                mon_e = exp_q.pop_front();
                check("quotient", quotient, mon_e.q);
                check("remainder", remainder, mon_e.r);
                check("div_by_zero", W'(div_by_zero), W'(mon_e.z));
            end
        end
        done_prev <= done;
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back(model(a, b));
    endtask

    // Count edges after the accept edge until done, bounded
    task automatic wait_done(output int c);
        c = 0;
        while (!done && c < W + 8) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("done_clear_after_ack", W'(done), W'(0));
        check("dbz_clear_after_ack", W'(div_by_zero), W'(0));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        int   c;
        exp_t e;
        e = model(a, b);
        issue(a, b);
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        wait_done(c);
        check("latency", W'(c), (b == 0) ? W'(0) : W'(W));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_done", W'(done), W'(1));
            check("hold_quotient", quotient, e.q);
            check("hold_remainder", remainder, e.r);
        end
        do_ack();
    endtask

    initial begin
        int c;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_quotient", quotient, '0);
        check("rst_remainder", remainder, '0);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_dbz", W'(div_by_zero), W'(0));
        rst_n = 1'b1;

        run_op(32'd100, 32'd7, 5);
        run_op(32'd7, 32'd100, 0);
        run_op(32'hFFFFFFFF, 32'd1, 0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(32'd5, 32'd0, 0);
        run_op(32'h80000000, 32'hFFFFFFFF, 0);

        // Asynchronous reset part-way through 1000/3
        issue(32'd1000, 32'd3);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_mid_op", W'(busy), W'(1));
        #2 rst_n = 1'b0;
        #1;
        check("abort_quotient", quotient, '0);
        check("abort_remainder", remainder, '0);
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_dbz", W'(div_by_zero), W'(0));
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd10, 32'd3, 0);

        // start and ack together in DONE: ack wins, nothing new starts
        issue(32'd200, 32'd9);
        @(negedge clk);
        start = 1'b0;
        wait_done(c);
        check("latency_200_9", W'(c), W'(W));
        start = 1'b1;
        ack   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ack   = 1'b0;
        check("both_high_done", W'(done), W'(0));
        check("both_high_busy", W'(busy), W'(0));
        @(negedge clk);
        check("both_high_no_start", W'(busy), W'(0));
        run_op(32'hFFFFFFF9, 32'd2, 0);

        // start held high across DONE and ack: next op accepted on the first INIT edge
        issue(32'd50, 32'd5);
        wait_done(c);
        check("latency_held_start", W'(c), W'(W + 1));
        ack      = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd7;
        @(negedge clk);
        ack = 1'b0;
        check("held_start_init_busy", W'(busy), W'(0));
        exp_q.push_back(model(32'd77, 32'd7));
        @(negedge clk);
        start = 1'b0;
        check("held_start_accepted", W'(busy), W'(1));
        wait_done(c);
        do_ack();

        // Randomised operands, with small and zero divisors mixed in
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            case ($urandom_range(0, 7))
                0, 1, 2: b = $urandom;
                3, 4:    b = $urandom_range(1, 15);
                5, 6:    b = $urandom >> $urandom_range(0, 31);
                default: b = '0;
            endcase
            run_op(a, b, 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", W'(exp_q.size()), W'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
